// File: rtl/bulls_cows_judge.sv
// Scoring engine for the xAyB number-guessing game.
// Latches a secret answer, then scores each guess one digit per cycle and
// tracks attempts against MAX_TRIES, reporting win/lose to the display side.
// Optional build macro BULLS_COWS_GUESS_CHECK_EN: reject guesses that hold a
// digit above 9 or a repeated digit instead of scoring them.
module bulls_cows_judge #(
  parameter int NUM_DIGITS = 3,
  parameter int DIGIT_W    = 4,
  parameter int MAX_TRIES  = 8,
  localparam int SCORE_W   = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] iNum,
  input  logic                          iNumRdy,
  input  logic                          iNew,
  output logic [SCORE_W-1:0]            oA,
  output logic [SCORE_W-1:0]            oB,
  output logic [3:0]                    oTries,
  output logic                          oResRdy,
  output logic                          oErr,
  output logic                          oArmed,
  output logic                          oWin,
  output logic                          oLose,
  output logic                          oBusy
);

  localparam int NumW = NUM_DIGITS * DIGIT_W;
  localparam int IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitGuess,
    StScore,
    StReport,
    StOver
  } state_e;

  state_e              state_q, state_d;
  logic [NumW-1:0]     answer_q, answer_d;
  logic [NumW-1:0]     guess_q, guess_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [SCORE_W-1:0]  acc_a_q, acc_a_d;
  logic [SCORE_W-1:0]  acc_b_q, acc_b_d;
  logic [SCORE_W-1:0]  a_q, a_d;
  logic [SCORE_W-1:0]  b_q, b_d;
  logic [3:0]          tries_q, tries_d;
  logic                res_rdy_q, res_rdy_d;
  logic                err_q, err_d;
  logic                armed_q, armed_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;
  logic                busy_q, busy_d;

  logic [DIGIT_W-1:0]  cur_guess;
  logic [DIGIT_W-1:0]  cur_ans;
  logic                pos_hit;
  logic                any_hit;
  logic                answer_ok;
  logic                guess_ok;

  // Every digit must be a decimal value and no two digits may be equal.
  function automatic logic digits_ok(input logic [NumW-1:0] num);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (num[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) ok = 1'b0;
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (num[i*DIGIT_W +: DIGIT_W] == num[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Input validation for the answer and, optionally, for guesses.
  always_comb begin
    answer_ok = digits_ok(iNum);
`ifdef BULLS_COWS_GUESS_CHECK_EN
    guess_ok  = answer_ok;
`else
    guess_ok  = 1'b1;
`endif
  end

  // Per-digit compare of the guess digit selected by idx_q against the answer.
  always_comb begin
    cur_guess = '0;
    cur_ans   = '0;
    any_hit   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IdxW'(i) == idx_q) begin
        cur_guess = guess_q[i*DIGIT_W +: DIGIT_W];
        cur_ans   = answer_q[i*DIGIT_W +: DIGIT_W];
      end
    end
    pos_hit = (cur_guess == cur_ans);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IdxW'(j) != idx_q) && (cur_guess == answer_q[j*DIGIT_W +: DIGIT_W])) begin
        any_hit = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic; iNew overrides everything.
  always_comb begin
    state_d   = state_q;
    answer_d  = answer_q;
    guess_d   = guess_q;
    idx_d     = idx_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    a_d       = a_q;
    b_d       = b_q;
    tries_d   = tries_q;
    res_rdy_d = 1'b0;
    err_d     = 1'b0;
    armed_d   = armed_q;
    win_d     = win_q;
    lose_d    = lose_q;
    busy_d    = busy_q;

    if (iNew) begin
      state_d = StIdle;
      idx_d   = '0;
      acc_a_d = '0;
      acc_b_d = '0;
      a_d     = '0;
      b_d     = '0;
      tries_d = '0;
      armed_d = 1'b0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iNumRdy) begin
            if (answer_ok) begin
              answer_d = iNum;
              armed_d  = 1'b1;
              state_d  = StWaitGuess;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StWaitGuess: begin
          if (iNumRdy) begin
            if (guess_ok) begin
              guess_d = iNum;
              acc_a_d = '0;
              acc_b_d = '0;
              idx_d   = '0;
              busy_d  = 1'b1;
              if (tries_q != 4'(MAX_TRIES)) tries_d = tries_q + 4'd1;
              state_d = StScore;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StScore: begin
          if (pos_hit) begin
            acc_a_d = acc_a_q + SCORE_W'(1);
          end else if (any_hit) begin
            acc_b_d = acc_b_q + SCORE_W'(1);
          end
          if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
            state_d = StReport;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StReport: begin
          a_d       = acc_a_q;
          b_d       = acc_b_q;
          res_rdy_d = 1'b1;
          busy_d    = 1'b0;
          if (acc_a_q == SCORE_W'(NUM_DIGITS)) begin
            win_d   = 1'b1;
            state_d = StOver;
          end else if (tries_q == 4'(MAX_TRIES)) begin
            lose_d  = 1'b1;
            state_d = StOver;
          end else begin
            state_d = StWaitGuess;
          end
        end
        StOver: begin
          state_d = StOver;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      answer_q  <= '0;
      guess_q   <= '0;
      idx_q     <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tries_q   <= '0;
      res_rdy_q <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      answer_q  <= answer_d;
      guess_q   <= guess_d;
      idx_q     <= idx_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tries_q   <= tries_d;
      res_rdy_q <= res_rdy_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      busy_q    <= busy_d;
    end
  end

  assign oA      = a_q;
  assign oB      = b_q;
  assign oTries  = tries_q;
  assign oResRdy = res_rdy_q;
  assign oErr    = err_q;
  assign oArmed  = armed_q;
  assign oWin    = win_q;
  assign oLose   = lose_q;
  assign oBusy   = busy_q;

endmodule

// File: tb/tb_bulls_cows_judge.sv
// Self-checking bench for bulls_cows_judge (3 digits, MAX_TRIES = 2).
// Expected scores are queued when a guess is driven and compared when
// oResRdy pulses.
module tb_bulls_cows_judge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] iNum = '0;
  logic        iNumRdy = 1'b0;
  logic        iNew = 1'b0;
  logic [1:0]  oA, oB;
  logic [3:0]  oTries;
  logic        oResRdy, oErr, oArmed, oWin, oLose, oBusy;

  bulls_cows_judge #(
    .NUM_DIGITS(3),
    .DIGIT_W   (4),
    .MAX_TRIES (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .iNum   (iNum),
    .iNumRdy(iNumRdy),
    .iNew   (iNew),
    .oA     (oA),
    .oB     (oB),
    .oTries (oTries),
    .oResRdy(oResRdy),
    .oErr   (oErr),
    .oArmed (oArmed),
    .oWin   (oWin),
    .oLose  (oLose),
    .oBusy  (oBusy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] tries;
    logic       win;
    logic       lose;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   drive_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] p3(input int d0, input int d1, input int d2);
    return {4'(d2), 4'(d1), 4'(d0)};
  endfunction

  function automatic exp_t mk(input int a, input int b, input int t, input bit w, input bit l);
    exp_t e;
    e.a = 2'(a);
    e.b = 2'(b);
    e.tries = 4'(t);
    e.win = w;
    e.lose = l;
    return e;
  endfunction

  // Reference scorer working on whole numbers at once.
  function automatic exp_t model(input logic [11:0] ans, input logic [11:0] g, input int t);
    int a = 0;
    int b = 0;
    logic [3:0] ad[3];
    logic [3:0] gd[3];
    for (int i = 0; i < 3; i++) begin
      ad[i] = ans[i*4 +: 4];
      gd[i] = g[i*4 +: 4];
    end
    for (int i = 0; i < 3; i++) begin
      if (gd[i] == ad[i]) a++;
      else if (gd[i] == ad[0] || gd[i] == ad[1] || gd[i] == ad[2]) b++;
    end
    return mk(a, b, t, a == 3, (a != 3) && (t == 2));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: pop the scoreboard on every oResRdy pulse.
  always @(negedge clk) begin
    if (reset && oResRdy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("res_a", oA, mon_e.a);
        check("res_b", oB, mon_e.b);
        check("res_tries", oTries, mon_e.tries);
        check("res_win", oWin, mon_e.win);
        check("res_lose", oLose, mon_e.lose);
        check("res_latency", cyc - drive_cyc, 5);
      end
    end
  end

  task automatic send(input logic [11:0] num);
    iNum = num;
    iNumRdy = 1'b1;
    drive_cyc = cyc;
    @(negedge clk);
    iNumRdy = 1'b0;
  endtask

  task automatic guess(input logic [11:0] num, input exp_t e);
    sb_q.push_back(e);
    send(num);
  endtask

  task automatic new_game();
    iNew = 1'b1;
    @(negedge clk);
    iNew = 1'b0;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("sb_timeout", sb_q.size(), 0);
  endtask

  function automatic logic [11:0] rand_distinct();
    int d0, d1, d2;
    d0 = $urandom_range(0, 9);
    do d1 = $urandom_range(0, 9); while (d1 == d0);
    do d2 = $urandom_range(0, 9); while (d2 == d0 || d2 == d1);
    return p3(d0, d1, d2);
  endfunction

  logic [11:0] ans, g;
  exp_t        e;

  initial begin
    #3;
    check("rst_outputs", {oA, oB, oTries, oResRdy, oErr, oArmed, oWin, oLose, oBusy}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Game 1: answer 1,2,3.
    send(p3(1, 2, 3));
    check("g1_armed", oArmed, 1);
    check("g1_err", oErr, 0);
    guess(p3(3, 2, 1), mk(1, 2, 1, 0, 0));
    check("g1_busy", oBusy, 1);
    wait_sb();
    check("g1_busy_done", oBusy, 0);
`ifdef BULLS_COWS_GUESS_CHECK_EN
    send(p3(5, 5, 3));
    check("g1_rep_err", oErr, 1);
    check("g1_rep_tries", oTries, 1);
    @(negedge clk);
    check("g1_err_pulse", oErr, 0);
    guess(p3(1, 2, 3), mk(3, 0, 2, 1, 0));
    wait_sb();
`else
    guess(p3(5, 5, 3), mk(1, 0, 2, 0, 1));
    check("g1_rep_err", oErr, 0);
    check("g1_rep_tries", oTries, 2);
    wait_sb();
`endif

    // Game 2: immediate win, then a guess in OVER is ignored.
    new_game();
    check("new_tries", oTries, 0);
    check("new_armed", oArmed, 0);
    check("new_flags", {oWin, oLose, oA, oB}, 0);
    send(p3(4, 5, 6));
    guess(p3(4, 5, 6), mk(3, 0, 1, 1, 0));
    wait_sb();
    send(p3(1, 2, 3));
    check("over_err", oErr, 0);
    repeat (8) @(negedge clk);
    check("over_tries", oTries, 1);
    check("over_win", oWin, 1);
    check("over_lose", oLose, 0);

    // Game 3: lose on the last try.
    new_game();
    send(p3(7, 8, 9));
    guess(p3(0, 1, 2), mk(0, 0, 1, 0, 0));
    wait_sb();
    guess(p3(9, 7, 8), mk(0, 3, 2, 0, 1));
    wait_sb();

    // Game 4: invalid answers, then abort during scoring.
    new_game();
    send(p3(1, 1, 2));
    check("dup_err", oErr, 1);
    check("dup_armed", oArmed, 0);
    @(negedge clk);
    check("dup_err_pulse", oErr, 0);
    send(p3(1, 10, 2));
    check("big_err", oErr, 1);
    check("big_armed", oArmed, 0);
    send(p3(1, 0, 2));
    check("ok_armed", oArmed, 1);
    check("ok_err", oErr, 0);
    send(p3(2, 1, 0));
    @(negedge clk);
    iNew = 1'b1;
    iNumRdy = 1'b1;
    @(negedge clk);
    iNew = 1'b0;
    iNumRdy = 1'b0;
    check("abort_busy", oBusy, 0);
    check("abort_tries", oTries, 0);
    check("abort_armed", oArmed, 0);
    repeat (8) @(negedge clk);
    check("abort_idle_armed", oArmed, 0);

    // Asynchronous reset in the middle of scoring.
    send(p3(1, 2, 3));
    send(p3(3, 2, 1));
    #2 reset = 1'b0;
    #1;
    check("async_rst", {oA, oB, oTries, oResRdy, oErr, oArmed, oWin, oLose, oBusy}, 0);
    #1 reset = 1'b1;
    @(negedge clk);

    // Random games against the reference scorer.
    for (int gm = 0; gm < 6; gm++) begin
      new_game();
      ans = rand_distinct();
      send(ans);
      for (int t = 1; t <= 2; t++) begin
        g = (gm == 0 && t == 2) ? ans : rand_distinct();
        e = model(ans, g, t);
        guess(g, e);
        wait_sb();
        if (e.win) break;
      end
    end

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bulls_cows_judge.md
Name: bulls_cows_judge

Overview:
- Parametrised scoring engine for the xAyB number-guessing game.
- Latches a secret answer, scores each later guess sequentially, counts attempts against a limit, and reports win/lose.
- Sits between the keypad/number-entry block (iNum/iNumRdy source) and the VGA text overlay, which reads oA, oB, oTries and the status flags for display.

Parameters:
- NUM_DIGITS, 3, digits per answer/guess (2..8)
- DIGIT_W, 4, bits per digit; legal digit values 0..9
- MAX_TRIES, 8, guesses allowed per game (1..15)
- SCORE_W, $clog2(NUM_DIGITS+1), width of A/B counts (derived, not overridden)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- iNum  input  NUM_DIGITS*DIGIT_W  packed digits; iNum[DIGIT_W-1:0] is digit 0 (leftmost on screen)
- iNumRdy  input  1  one-cycle strobe: iNum valid
- iNew  input  1  one-cycle strobe: start new game
- oA  output  SCORE_W  correct digit, correct position count of last scored guess
- oB  output  SCORE_W  correct digit, wrong position count of last scored guess
- oTries  output  4  guesses consumed this game
- oResRdy  output  1  one-cycle pulse: oA/oB updated
- oErr  output  1  one-cycle pulse: input rejected
- oArmed  output  1  answer latched, game in progress
- oWin  output  1  level: game won
- oLose  output  1  level: tries exhausted without win
- oBusy  output  1  scoring in progress

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE
  - all outputs 0
  - answer and guess registers 0
  - digit index 0
- States: IDLE, WAIT_GUESS, SCORE, REPORT, OVER.
- IDLE:
  - On iNumRdy, validate iNum: every digit <=9 and all digits pairwise distinct.
  - Valid: latch iNum as answer next edge, go to WAIT_GUESS, oArmed=1.
  - Invalid: oErr pulses 1 cycle, stay in IDLE.
- WAIT_GUESS:
  - On iNumRdy, latch guess, clear A/B accumulators, index=0, go to SCORE, oBusy=1.
  - oTries increments on that same edge.
- SCORE:
  - One digit per cycle for NUM_DIGITS cycles.
  - For index i: if guess[i]==answer[i], A+=1; else if guess[i] equals any answer[j] with j!=i, B+=1.
  - After index NUM_DIGITS-1, go to REPORT.
- REPORT (1 cycle):
  - Copy accumulators to oA/oB, pulse oResRdy, oBusy=0.
  - If A==NUM_DIGITS: oWin=1, go to OVER.
  - Else if oTries==MAX_TRIES: oLose=1, go to OVER.
  - Else go to WAIT_GUESS.
- Latency: iNumRdy to oResRdy is NUM_DIGITS+2 cycles (3 digits → 5 cycles).
- iNumRdy during SCORE, REPORT or OVER is ignored: no oErr, no try consumed.
- OVER: holds oA, oB, oTries, oWin, oLose until iNew.
- iNew (any state, including mid-SCORE):
  - Abort any scoring, go to IDLE next edge.
  - Clear oA, oB, oTries, oWin, oLose, oArmed, oBusy. Answer register contents don't-care.
  - Priority over a coincident iNumRdy, which is dropped.
- Guess digits >9 are scored as-is (never match), still consume a try unless GUESS_CHECK_EN is defined.
- oTries saturates at MAX_TRIES and never wraps.
- oWin and oLose are mutually exclusive. A win on the final try reports oWin=1, oLose=0.

Optional Feature:
- Macro: BULLS_COWS_GUESS_CHECK_EN.
- Defined: in WAIT_GUESS, a guess with any digit >9 or any repeated digit is rejected. oErr pulses, no try is consumed, state is unchanged.
- Not defined: every guess is accepted and scored per the rules above. oErr fires only for an invalid answer in IDLE.

Test Plan:
- Answer 1,2,3; guess 3,2,1 → after 5 cycles oResRdy pulse, oA=1, oB=2, oTries=1, oWin=0.
- Answer 4,5,6; guess 4,5,6 → oA=3, oB=0, oWin=1, state OVER. A further iNumRdy leaves oTries=1 and produces no oResRdy.
- Answer 7,8,9, MAX_TRIES=2; guesses 0,1,2 then 9,7,8 → first oA=0, oB=0; second oA=0, oB=3, oTries=2, oLose=1.
- Answer 1,1,2 in IDLE → oErr pulse, oArmed stays 0. Then answer 1,0,2 → oArmed=1.
- iNew asserted on the second SCORE cycle → next cycle IDLE, oBusy=0, oTries=0, no oResRdy. reset low mid-game → all outputs 0 immediately, with no clock edge needed.
- With BULLS_COWS_GUESS_CHECK_EN: guess 5,5,3 → oErr pulse, oTries unchanged. Without it: the same guess is scored normally and oTries increments.
